// File: rtl/svf_sched_pkg.sv
// Shared definitions for the SVF voice scheduler: FSM state codes,
// overrun counter width and a saturating increment helper.
package svf_sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ISSUE  = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_COMMIT = 2'd3;

    localparam int OVR_W = 8;

    // Saturating +1 for the dropped-edge counter.
    function automatic logic [OVR_W-1:0] ovr_sat_inc(input logic [OVR_W-1:0] v);
        logic [OVR_W-1:0] r;
        if (v == {OVR_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(OVR_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/svf_sched_edge.sv
// Rising-edge detector for the sample_clk level strobe (synchronous to clk).
module svf_sched_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic edge_o
);

    logic sig_q;

    // Remember the previous strobe level so a rising edge can be seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign edge_o = sig_i & ~sig_q;

endmodule

// File: rtl/svf_voice_scheduler.sv
// Time-multiplexes one stateless SVF compute core over N_CH channels.
// Each sample_clk rising edge snapshots the inputs, issues one request per
// channel in order (one outstanding at a time), keeps the per-channel lp/bp
// integrator state, and publishes all outputs together in one COMMIT cycle.
// Optional build macro SVF_SCHED_MASK_EN adds a per-channel enable mask ch_en.
module svf_voice_scheduler
    import svf_sched_pkg::*;
#(
    parameter int W    = 16,
    parameter int N_CH = 4,
    parameter int CW   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_clk,
    input  logic [N_CH*W-1:0]   in_flat,
    input  logic [N_CH*W-1:0]   f_flat,
    input  logic [W-1:0]        q1,
`ifdef SVF_SCHED_MASK_EN
    input  logic [N_CH-1:0]     ch_en,
`endif
    output logic                core_valid,
    input  logic                core_ready,
    output logic [W-1:0]        core_in,
    output logic [W-1:0]        core_f,
    output logic [W-1:0]        core_q1,
    output logic [W-1:0]        core_lp_z,
    output logic [W-1:0]        core_bp_z,
    input  logic                core_rsp_valid,
    input  logic [W-1:0]        core_hp,
    input  logic [W-1:0]        core_lp,
    input  logic [W-1:0]        core_bp,
    input  logic [W-1:0]        core_notch,
    output logic [N_CH*W-1:0]   hp_flat,
    output logic [N_CH*W-1:0]   lp_flat,
    output logic [N_CH*W-1:0]   bp_flat,
    output logic [N_CH*W-1:0]   notch_flat,
    output logic                busy,
    output logic [OVR_W-1:0]    overrun_cnt
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            edge_s;
    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [IDX_W-1:0] ch_idx_s;

    logic [W-1:0] in_sh_q  [N_CH];
    logic [W-1:0] f_sh_q   [N_CH];
    logic [W-1:0] q1_sh_q;
    logic [W-1:0] lp_st_q  [N_CH];
    logic [W-1:0] bp_st_q  [N_CH];
    logic [W-1:0] hp_stg_q [N_CH];
    logic [W-1:0] lp_stg_q [N_CH];
    logic [W-1:0] bp_stg_q [N_CH];
    logic [W-1:0] nt_stg_q [N_CH];
    logic [OVR_W-1:0] ovr_q;

    // en_now_s: mask presented at the edge; en_tick_s: mask of the tick in flight
    logic [N_CH-1:0] en_now_s;
    logic [N_CH-1:0] en_tick_s;
    logic [CW-1:0]   first_ch_s, next_ch_s;
    logic            first_ok_s, next_ok_s;

`ifdef SVF_SCHED_MASK_EN
    logic [N_CH-1:0] en_q;
    assign en_now_s  = ch_en;
    assign en_tick_s = en_q;
`else
    assign en_now_s  = {N_CH{1'b1}};
    assign en_tick_s = {N_CH{1'b1}};
`endif

    svf_sched_edge u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (sample_clk),
        .edge_o (edge_s)
    );

    assign ch_idx_s    = ch_q[IDX_W-1:0];
    assign busy        = (state_q != ST_IDLE);
    assign core_valid  = (state_q == ST_ISSUE);
    assign core_in     = in_sh_q[ch_idx_s];
    assign core_f      = f_sh_q[ch_idx_s];
    assign core_q1     = q1_sh_q;
    assign core_lp_z   = lp_st_q[ch_idx_s];
    assign core_bp_z   = bp_st_q[ch_idx_s];
    assign overrun_cnt = ovr_q;

    // Find the first enabled channel of a new tick and the next one after ch_q.
    always_comb begin
        first_ch_s = {CW{1'b0}};
        first_ok_s = 1'b0;
        next_ch_s  = {CW{1'b0}};
        next_ok_s  = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            first_ok_s = first_ok_s | en_now_s[i];
            first_ch_s = en_now_s[i] ? CW'(i) : first_ch_s;
            next_ok_s  = next_ok_s | (en_tick_s[i] && (i > int'(ch_q)));
            next_ch_s  = (en_tick_s[i] && (i > int'(ch_q))) ? CW'(i) : next_ch_s;
        end
    end

    // Sequencer next-state: IDLE -> ISSUE <-> WAIT -> COMMIT -> IDLE.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_s) begin
                    if (first_ok_s) begin
                        ch_d    = first_ch_s;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (core_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (core_rsp_valid) begin
                    if (next_ok_s) begin
                        ch_d    = next_ch_s;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = {CW{1'b0}};
            end
        endcase
    end

    // Sequencer state and current channel registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Shadow snapshot, channel state and staging updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1_sh_q <= {W{1'b0}};
            for (int c = 0; c < N_CH; c++) begin
                in_sh_q[c]  <= {W{1'b0}};
                f_sh_q[c]   <= {W{1'b0}};
                lp_st_q[c]  <= {W{1'b0}};
                bp_st_q[c]  <= {W{1'b0}};
                hp_stg_q[c] <= {W{1'b0}};
                lp_stg_q[c] <= {W{1'b0}};
                bp_stg_q[c] <= {W{1'b0}};
                nt_stg_q[c] <= {W{1'b0}};
            end
`ifdef SVF_SCHED_MASK_EN
            en_q <= {N_CH{1'b0}};
`endif
        end else begin
            if (edge_s && (state_q == ST_IDLE)) begin
                q1_sh_q <= q1;
`ifdef SVF_SCHED_MASK_EN
                en_q <= ch_en;
`endif
                for (int c = 0; c < N_CH; c++) begin
                    in_sh_q[c] <= in_flat[c*W +: W];
                    f_sh_q[c]  <= f_flat[c*W +: W];
                    // Disabled channels lose their state and publish zero.
                    if (!en_now_s[c]) begin
                        lp_st_q[c]  <= {W{1'b0}};
                        bp_st_q[c]  <= {W{1'b0}};
                        hp_stg_q[c] <= {W{1'b0}};
                        lp_stg_q[c] <= {W{1'b0}};
                        bp_stg_q[c] <= {W{1'b0}};
                        nt_stg_q[c] <= {W{1'b0}};
                    end
                end
            end
            if ((state_q == ST_WAIT) && core_rsp_valid) begin
                lp_st_q[ch_idx_s]  <= core_lp;
                bp_st_q[ch_idx_s]  <= core_bp;
                hp_stg_q[ch_idx_s] <= core_hp;
                lp_stg_q[ch_idx_s] <= core_lp;
                bp_stg_q[ch_idx_s] <= core_bp;
                nt_stg_q[ch_idx_s] <= core_notch;
            end
        end
    end

    // Publish the whole staged sample set at once, only in COMMIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hp_flat    <= {(N_CH*W){1'b0}};
            lp_flat    <= {(N_CH*W){1'b0}};
            bp_flat    <= {(N_CH*W){1'b0}};
            notch_flat <= {(N_CH*W){1'b0}};
        end else if (state_q == ST_COMMIT) begin
            for (int c = 0; c < N_CH; c++) begin
                hp_flat[c*W +: W]    <= hp_stg_q[c];
                lp_flat[c*W +: W]    <= lp_stg_q[c];
                bp_flat[c*W +: W]    <= bp_stg_q[c];
                notch_flat[c*W +: W] <= nt_stg_q[c];
            end
        end else begin
            hp_flat    <= hp_flat;
            lp_flat    <= lp_flat;
            bp_flat    <= bp_flat;
            notch_flat <= notch_flat;
        end
    end

    // Count sample edges that arrive while a tick is still in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_q <= {OVR_W{1'b0}};
        end else if (edge_s && (state_q != ST_IDLE)) begin
            ovr_q <= ovr_sat_inc(ovr_q);
        end else begin
            ovr_q <= ovr_q;
        end
    end

endmodule

// File: tb/tb_svf_voice_scheduler.sv
// Self-checking bench for svf_voice_scheduler (N_CH=4, W=16) with a
// behavioural core model and a per-tick reference of channel state/outputs.
module tb_svf_voice_scheduler;

    localparam int W    = 16;
    localparam int N_CH = 4;
    localparam int CW   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sample_clk = 1'b0;
    logic [N_CH*W-1:0] in_flat = '0;
    logic [N_CH*W-1:0] f_flat = '0;
    logic [W-1:0]      q1 = '0;
    logic              core_ready = 1'b1;
    logic              core_rsp_valid = 1'b0;
    logic [W-1:0]      core_hp = '0, core_lp = '0, core_bp = '0, core_notch = '0;
`ifdef SVF_SCHED_MASK_EN
    logic [N_CH-1:0]   ch_en = 4'b1111;
`endif

    logic              core_valid, busy;
    logic [W-1:0]      core_in, core_f, core_q1, core_lp_z, core_bp_z;
    logic [N_CH*W-1:0] hp_flat, lp_flat, bp_flat, notch_flat;
    logic [7:0]        overrun_cnt;

    svf_voice_scheduler #(.W(W), .N_CH(N_CH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk),
        .in_flat(in_flat), .f_flat(f_flat), .q1(q1),
`ifdef SVF_SCHED_MASK_EN
        .ch_en(ch_en),
`endif
        .core_valid(core_valid), .core_ready(core_ready),
        .core_in(core_in), .core_f(core_f), .core_q1(core_q1),
        .core_lp_z(core_lp_z), .core_bp_z(core_bp_z),
        .core_rsp_valid(core_rsp_valid),
        .core_hp(core_hp), .core_lp(core_lp), .core_bp(core_bp), .core_notch(core_notch),
        .hp_flat(hp_flat), .lp_flat(lp_flat), .bp_flat(bp_flat), .notch_flat(notch_flat),
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [W-1:0] in_v, f_v, q1_v, lpz, bpz;
    } req_t;

    req_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Core model controls
    int   core_mode = 0;
    int   core_lat = 2;
    int   stall_idx = -1;
    int   stall_len = 0;
    int   req_in_tick = 0;
    bit   commit_pulse = 1'b0;

    // Reference model state
    logic [W-1:0]      lp_ref [N_CH];
    logic [W-1:0]      bp_ref [N_CH];
    logic [N_CH*W-1:0] pub_hp = '0, pub_lp = '0, pub_bp = '0, pub_nt = '0;
    int                ovr_exp = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behaviour of the stand-in compute core (arbitrary but deterministic).
    function automatic void core_fn(input int ch, input int mode,
                                    input logic [W-1:0] in_v, f_v, q1_v, lpz, bpz,
                                    output logic [W-1:0] hp, lp, bp, nt);
        hp = in_v - lpz;
        lp = (mode != 0) ? 16'(ch + 10) : (lpz + f_v);
        bp = bpz ^ in_v ^ f_v;
        nt = in_v + q1_v;
    endfunction

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Core model: checks each request against the expected queue, stalls on demand, responds after core_lat.
    initial begin : core_model
        req_t e;
        int ch, idx;
        bit stable;
        logic [5*W-1:0] snap;
        logic [W-1:0] hp, lp, bp, nt;
        forever begin
            @(negedge clk);
            if (core_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_req", 64'd1, 64'd0);
                    ch = 0;
                end else begin
                    e  = exp_q.pop_front();
                    ch = e.ch;
                    check_val("req_in",  core_in,   e.in_v);
                    check_val("req_f",   core_f,    e.f_v);
                    check_val("req_q1",  core_q1,   e.q1_v);
                    check_val("req_lpz", core_lp_z, e.lpz);
                    check_val("req_bpz", core_bp_z, e.bpz);
                end
                snap = {core_in, core_f, core_q1, core_lp_z, core_bp_z};
                idx = req_in_tick;
                req_in_tick++;
                if ((idx == stall_idx) && (stall_len > 0)) begin
                    core_ready = 1'b0;
                    stable = 1'b1;
                    repeat (stall_len) begin
                        @(negedge clk);
                        if ((core_valid !== 1'b1) ||
                            ({core_in, core_f, core_q1, core_lp_z, core_bp_z} !== snap))
                            stable = 1'b0;
                    end
                    check_val("stall_stable", {63'd0, stable}, 64'd1);
                    core_ready = 1'b1;
                end
                @(posedge clk);
                core_fn(ch, core_mode, snap[5*W-1 -: W], snap[4*W-1 -: W], snap[3*W-1 -: W],
                        snap[2*W-1 -: W], snap[W-1:0], hp, lp, bp, nt);
                repeat (core_lat - 1) @(posedge clk);
                #1;
                core_rsp_valid = 1'b1;
                core_hp = hp; core_lp = lp; core_bp = bp; core_notch = nt;
                @(posedge clk);
                #1;
                core_rsp_valid = 1'b0;
                if (commit_pulse && (idx == N_CH - 1)) begin
                    sample_clk = 1'b1;
                    @(posedge clk);
                    #1;
                    sample_clk = 1'b0;
                    commit_pulse = 1'b0;
                end
            end
        end
    end

    // Build the expected request list and the expected published set for one tick.
    task automatic ref_prepare(output int n);
        logic [N_CH-1:0] en_ref;
        req_t e;
        logic [W-1:0] hp, lp, bp, nt;
`ifdef SVF_SCHED_MASK_EN
        en_ref = ch_en;
`else
        en_ref = {N_CH{1'b1}};
`endif
        n = 0;
        for (int c = 0; c < N_CH; c++) begin
            if (en_ref[c]) begin
                e.ch = c; e.in_v = in_flat[c*W +: W]; e.f_v = f_flat[c*W +: W];
                e.q1_v = q1; e.lpz = lp_ref[c]; e.bpz = bp_ref[c];
                exp_q.push_back(e);
                core_fn(c, core_mode, e.in_v, e.f_v, e.q1_v, e.lpz, e.bpz, hp, lp, bp, nt);
                lp_ref[c] = lp; bp_ref[c] = bp;
                pub_hp[c*W +: W] = hp; pub_lp[c*W +: W] = lp;
                pub_bp[c*W +: W] = bp; pub_nt[c*W +: W] = nt;
                n++;
            end else begin
                lp_ref[c] = '0; bp_ref[c] = '0;
                pub_hp[c*W +: W] = '0; pub_lp[c*W +: W] = '0;
                pub_bp[c*W +: W] = '0; pub_nt[c*W +: W] = '0;
            end
        end
    endtask

    task automatic start_edge();
        @(posedge clk);
        #1 sample_clk = 1'b1;
        @(posedge clk);
        #1 sample_clk = 1'b0;
    endtask

    task automatic randomize_inputs();
        in_flat = {$urandom, $urandom};
        f_flat  = {$urandom, $urandom};
        q1      = 16'($urandom);
    endtask

    // One full tick: n_mid extra edges while busy, optional edge in the COMMIT cycle.
    task automatic do_tick(input int mode, input int n_mid, input bit cpulse);
        logic [4*N_CH*W-1:0] old_pub;
        bit early, mine, done;
        int mid_sent, n_exp;
        old_pub = {pub_hp, pub_lp, pub_bp, pub_nt};
        core_mode = mode;
        req_in_tick = 0;
        commit_pulse = cpulse;
        ref_prepare(n_exp);
        if (cpulse) ovr_exp = sat(ovr_exp);
        start_edge();
        early = 1'b0; mine = 1'b0; done = 1'b0; mid_sent = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            if ({hp_flat, lp_flat, bp_flat, notch_flat} !== old_pub) early = 1'b1;
            if (k == 2) randomize_inputs();
            if (mine) begin
                sample_clk = 1'b0;
                mine = 1'b0;
            end else if ((mid_sent < n_mid) && (k >= 3)) begin
                sample_clk = 1'b1;
                mine = 1'b1;
                mid_sent++;
                ovr_exp = sat(ovr_exp);
            end
        end
        if (mine) sample_clk = 1'b0;
        check_val("tick_done",    {63'd0, done}, 64'd1);
        check_val("early_update", {63'd0, early}, 64'd0);
        check_val("hp_flat",    hp_flat,    pub_hp);
        check_val("lp_flat",    lp_flat,    pub_lp);
        check_val("bp_flat",    bp_flat,    pub_bp);
        check_val("notch_flat", notch_flat, pub_nt);
        check_val("req_count",  64'(req_in_tick), 64'(n_exp));
        check_val("req_left",   64'(exp_q.size()), 64'd0);
        check_val("overrun",    {56'd0, overrun_cnt}, 64'(ovr_exp));
        check_val("valid_idle", {63'd0, core_valid}, 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : main
        bit got;
        int n_dummy;
        for (int c = 0; c < N_CH; c++) begin
            lp_ref[c] = '0;
            bp_ref[c] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_busy",    {63'd0, busy}, 64'd0);
        check_val("rst_valid",   {63'd0, core_valid}, 64'd0);
        check_val("rst_overrun", {56'd0, overrun_cnt}, 64'd0);
        check_val("rst_hp",      hp_flat, 64'd0);
        check_val("rst_lp",      lp_flat, 64'd0);

        // Tick 1: fixed inputs, core returns lp = ch + 10
        in_flat = {16'd400, 16'd300, 16'd200, 16'd100};
        f_flat  = {16'd4, 16'd3, 16'd2, 16'd1};
        q1      = 16'd7;
        do_tick(1, 0, 1'b0);

        // Tick 2: lp_z must carry 10..13
        randomize_inputs();
        do_tick(0, 0, 1'b0);

        // Tick 3: backpressure on channel 2
        randomize_inputs();
        stall_idx = 2; stall_len = 5;
        do_tick(0, 0, 1'b0);
        stall_idx = -1;

        // Tick 4: one edge mid-sequence and one in the COMMIT cycle
        randomize_inputs();
        do_tick(0, 1, 1'b1);
        check_val("overrun_two", {56'd0, overrun_cnt}, 64'd2);

        // Tick 5: 300 dropped edges during a long stall saturate the counter
        randomize_inputs();
        stall_idx = 1; stall_len = 700;
        do_tick(0, 300, 1'b0);
        stall_idx = -1;
        check_val("overrun_sat", {56'd0, overrun_cnt}, 64'd255);

        // Reset while waiting on channel 1
        randomize_inputs();
        core_lat = 3;
        core_mode = 0;
        req_in_tick = 0;
        ref_prepare(n_dummy);
        start_edge();
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (req_in_tick >= 2) begin
                got = 1'b1;
                break;
            end
        end
        check_val("reach_wait_ch1", {63'd0, got}, 64'd1);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        for (int c = 0; c < N_CH; c++) begin
            lp_ref[c] = '0;
            bp_ref[c] = '0;
        end
        pub_hp = '0; pub_lp = '0; pub_bp = '0; pub_nt = '0;
        ovr_exp = 0;
        @(negedge clk);
        check_val("mid_rst_hp",    hp_flat, 64'd0);
        check_val("mid_rst_lp",    lp_flat, 64'd0);
        check_val("mid_rst_bp",    bp_flat, 64'd0);
        check_val("mid_rst_notch", notch_flat, 64'd0);
        check_val("mid_rst_busy",  {63'd0, busy}, 64'd0);
        check_val("mid_rst_valid", {63'd0, core_valid}, 64'd0);
        check_val("mid_rst_ovr",   {56'd0, overrun_cnt}, 64'd0);
        repeat (6) @(negedge clk);
        check_val("late_rsp_ignored", lp_flat, 64'd0);
        check_val("late_rsp_busy",    {63'd0, busy}, 64'd0);
        core_lat = 2;
        randomize_inputs();
        do_tick(0, 0, 1'b0);

        // Randomized ticks with varying latency and stalls
        for (int t = 0; t < 10; t++) begin
            core_lat = int'($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) begin
                stall_idx = int'($urandom_range(0, N_CH - 1));
                stall_len = int'($urandom_range(1, 6));
            end else begin
                stall_idx = -1;
            end
            randomize_inputs();
            do_tick(0, int'($urandom_range(0, 2)), 1'b0);
        end
        stall_idx = -1;

`ifdef SVF_SCHED_MASK_EN
        ch_en = 4'b0101;
        randomize_inputs();
        do_tick(0, 0, 1'b0);
        ch_en = 4'b0000;
        do_tick(0, 0, 1'b0);
        ch_en = 4'b1111;
        randomize_inputs();
        do_tick(0, 0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
